// File: rtl/src_sel_pkg.sv
// Source-bus selector codes and the sign-extension helper shared by the
// operand bypass datapath.
package src_sel_pkg;

    localparam logic [1:0] RF2SRC0      = 2'd0;
    localparam logic [1:0] IMM_BR2SRC0  = 2'd1;
    localparam logic [1:0] IMM_JMP2SRC0 = 2'd2;
    localparam logic [1:0] IMM_DM2SRC0  = 2'd3;

    localparam logic [1:0] RF2SRC1      = 2'd0;
    localparam logic [1:0] NPC2SRC1     = 2'd1;
    localparam logic [1:0] IMM4_2SRC1   = 2'd2;
    localparam logic [1:0] IMM8_2SRC1   = 2'd3;

    localparam int SEXT_MAXW = 64;

    // Sign-extends the low w bits of v up to dw bits; bits at or above dw are zero.
    function automatic logic [SEXT_MAXW-1:0] sext(input logic [SEXT_MAXW-1:0] v,
                                                  input int unsigned w,
                                                  input int unsigned dw);
        logic [SEXT_MAXW-1:0] r;
        logic                 sb;
        r  = '0;
        sb = 1'b0;
        for (int i = 0; i < SEXT_MAXW; i++) begin
            if (i == int'(w) - 1) sb = v[i];
        end
        for (int i = 0; i < SEXT_MAXW; i++) begin
            if (i < int'(w))       r[i] = v[i];
            else if (i < int'(dw)) r[i] = sb;
            else                   r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Operand bus between the decode/hazard logic (master) and the operand bypass unit (slave).
interface operand_bypass_unit_if #(
    parameter int DW   = 16,
    parameter int NBYP = 2,
    parameter int IMMW = 12
);
    logic                 stall_ID_EX;
    logic                 stall_EX_DM;
    logic                 flush_ID_EX;
    logic [DW-1:0]        p0;
    logic [DW-1:0]        p1;
    logic [NBYP-1:0]      byp0_sel;
    logic [NBYP-1:0]      byp1_sel;
    logic [NBYP*DW-1:0]   byp_data;
    logic [IMMW-1:0]      imm_ID_EX;
    logic [DW-1:0]        pc_ID_EX;
    logic [1:0]           src0sel_ID_EX;
    logic [1:0]           src1sel_ID_EX;
    logic [DW-1:0]        src0;
    logic [DW-1:0]        src1;
    logic [DW-1:0]        p0_EX_DM;
    logic                 hold0;
    logic                 hold1;

    modport master (
        output stall_ID_EX, stall_EX_DM, flush_ID_EX, p0, p1, byp0_sel, byp1_sel,
               byp_data, imm_ID_EX, pc_ID_EX, src0sel_ID_EX, src1sel_ID_EX,
        input  src0, src1, p0_EX_DM, hold0, hold1
    );

    modport slave (
        input  stall_ID_EX, stall_EX_DM, flush_ID_EX, p0, p1, byp0_sel, byp1_sel,
               byp_data, imm_ID_EX, pc_ID_EX, src0sel_ID_EX, src1sel_ID_EX,
        output src0, src1, p0_EX_DM, hold0, hold1
    );

endinterface

// File: rtl/operand_bypass_unit_resolve.sv
// One source-operand port: ID_EX register, lowest-index-wins bypass mux, and a
// stall-hold register that freezes the resolved value across ID_EX stalls.
module operand_resolve #(
    parameter int DW   = 16,
    parameter int NBYP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [DW-1:0]      p,
    input  logic [NBYP-1:0]    sel,
    input  logic [NBYP*DW-1:0] byp_data,
    output logic [DW-1:0]      rf,
    output logic               hold
);

    logic [DW-1:0] p_id_ex_reg;
    logic [DW-1:0] hold_val_reg;
    logic          hold_reg;
    logic [DW-1:0] byp_val;

    // Scan from oldest to youngest so the lowest set index overwrites last.
    always_comb begin
        byp_val = p_id_ex_reg;
        for (int i = NBYP - 1; i >= 0; i--) begin
            if (sel[i]) byp_val = byp_data[i*DW +: DW];
        end
    end

    assign rf   = hold_reg ? hold_val_reg : byp_val;
    assign hold = hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_id_ex_reg  <= '0;
            hold_val_reg <= '0;
            hold_reg     <= 1'b0;
        end else if (flush) begin
            p_id_ex_reg  <= '0;
            hold_val_reg <= '0;
            hold_reg     <= 1'b0;
        end else if (!stall) begin
            p_id_ex_reg  <= p;
            hold_reg     <= 1'b0;
        end else if (!hold_reg) begin
            // First stalled edge: capture whatever was resolved this cycle.
            hold_reg     <= 1'b1;
            hold_val_reg <= rf;
        end
    end

endmodule

// File: rtl/operand_bypass_unit.sv
// ID/EX source-operand stage: two bypass-resolved operand ports, src0/src1 bus
// selection with immediate sign extension, and the EX_DM store-data register.
module operand_bypass_unit
    import src_sel_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NBYP = 2,
    parameter int IMMW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_bypass_unit_if.slave bus
);

    logic [DW-1:0]        p_arr   [2];
    logic [NBYP-1:0]      sel_arr [2];
    logic [DW-1:0]        rf      [2];
    logic                 hold    [2];
    logic [DW-1:0]        p0_ex_dm_reg;
    logic [DW-1:0]        src0_next;
    logic [DW-1:0]        src1_next;
    logic [SEXT_MAXW-1:0] imm_raw;
    logic [SEXT_MAXW-1:0] br_ext;
    logic [SEXT_MAXW-1:0] jmp_ext;
    logic [SEXT_MAXW-1:0] imm4_ext;
    logic [SEXT_MAXW-1:0] imm8_ext;

    assign p_arr[0]   = bus.p0;
    assign p_arr[1]   = bus.p1;
    assign sel_arr[0] = bus.byp0_sel;
    assign sel_arr[1] = bus.byp1_sel;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            operand_resolve #(
                .DW   (DW),
                .NBYP (NBYP)
            ) u_resolve (
                .clk      (clk),
                .rst_n    (rst_n),
                .stall    (bus.stall_ID_EX),
                .flush    (bus.flush_ID_EX),
                .p        (p_arr[gi]),
                .sel      (sel_arr[gi]),
                .byp_data (bus.byp_data),
                .rf       (rf[gi]),
                .hold     (hold[gi])
            );
        end
    endgenerate

    assign imm_raw  = SEXT_MAXW'(bus.imm_ID_EX[IMMW-1:0]);
    assign br_ext   = sext(imm_raw, 9,  DW);
    assign jmp_ext  = sext(imm_raw, 12, DW);
    assign imm4_ext = sext(imm_raw, 4,  DW);
    assign imm8_ext = sext(imm_raw, 8,  DW);

    always_comb begin
        src0_next = rf[0];
        unique case (bus.src0sel_ID_EX)
            RF2SRC0:      src0_next = rf[0];
            IMM_BR2SRC0:  src0_next = br_ext[DW-1:0];
            IMM_JMP2SRC0: src0_next = jmp_ext[DW-1:0];
            IMM_DM2SRC0:  src0_next = imm4_ext[DW-1:0];
            default:      src0_next = rf[0];
        endcase
    end

    always_comb begin
        src1_next = rf[1];
        unique case (bus.src1sel_ID_EX)
            RF2SRC1:    src1_next = rf[1];
            NPC2SRC1:   src1_next = bus.pc_ID_EX;
            IMM4_2SRC1: src1_next = imm4_ext[DW-1:0];
            IMM8_2SRC1: src1_next = imm8_ext[DW-1:0];
            default:    src1_next = rf[1];
        endcase
    end

    // Store data takes the resolved operand, so a held value is what gets stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                p0_ex_dm_reg <= '0;
        else if (!bus.stall_EX_DM) p0_ex_dm_reg <= rf[0];
    end

    assign bus.src0     = src0_next;
    assign bus.src1     = src1_next;
    assign bus.p0_EX_DM = p0_ex_dm_reg;
    assign bus.hold0    = hold[0];
    assign bus.hold1    = hold[1];

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed plus randomized bench for operand_bypass_unit against a behavioural model.
module tb_operand_bypass_unit;

    localparam int DW   = 16;
    localparam int NBYP = 2;
    localparam int IMMW = 12;

    logic clk;
    logic rst_n;

    operand_bypass_unit_if #(.DW(DW), .NBYP(NBYP), .IMMW(IMMW)) bus ();

    operand_bypass_unit #(.DW(DW), .NBYP(NBYP), .IMMW(IMMW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state: per-port ID_EX value, hold flag, held value; store register
    logic [15:0] m_pid  [2];
    logic        m_hold [2];
    logic [15:0] m_hv   [2];
    logic [15:0] m_store;
    logic [15:0] prev_store;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_sext(input logic [15:0] v, input int w);
        logic signed [15:0] t;
        t = $signed(v << (16 - w));
        return 16'(t >>> (16 - w));
    endfunction

    function automatic logic [15:0] m_rf(input int k);
        logic [NBYP-1:0] s;
        s = (k == 0) ? bus.byp0_sel : bus.byp1_sel;
        if (m_hold[k]) return m_hv[k];
        for (int i = 0; i < NBYP; i++)
            if (s[i]) return bus.byp_data[i*DW +: DW];
        return m_pid[k];
    endfunction

    function automatic logic [15:0] m_src0();
        case (bus.src0sel_ID_EX)
            2'd0:    return m_rf(0);
            2'd1:    return m_sext(16'(bus.imm_ID_EX[8:0]), 9);
            2'd2:    return m_sext(16'(bus.imm_ID_EX[11:0]), 12);
            default: return m_sext(16'(bus.imm_ID_EX[3:0]), 4);
        endcase
    endfunction

    function automatic logic [15:0] m_src1();
        case (bus.src1sel_ID_EX)
            2'd0:    return m_rf(1);
            2'd1:    return bus.pc_ID_EX;
            2'd2:    return m_sext(16'(bus.imm_ID_EX[3:0]), 4);
            default: return m_sext(16'(bus.imm_ID_EX[7:0]), 8);
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_pid[k] = '0; m_hold[k] = 1'b0; m_hv[k] = '0;
        end
        m_store = '0;
    endtask

    task automatic look();
        #2;
        check_eq("src0", 32'(bus.src0), 32'(m_src0()));
        check_eq("src1", 32'(bus.src1), 32'(m_src1()));
        check_eq("hold0", 32'(bus.hold0), 32'(m_hold[0]));
        check_eq("hold1", 32'(bus.hold1), 32'(m_hold[1]));
        check_eq("p0_EX_DM", 32'(bus.p0_EX_DM), 32'(m_store));
    endtask

    task automatic tick();
        logic [15:0] rfv [2];
        rfv[0] = m_rf(0);
        rfv[1] = m_rf(1);
        if (!bus.stall_EX_DM) m_store = rfv[0];
        for (int k = 0; k < 2; k++) begin
            if (bus.flush_ID_EX) begin
                m_pid[k] = '0; m_hold[k] = 1'b0; m_hv[k] = '0;
            end else if (!bus.stall_ID_EX) begin
                m_pid[k] = (k == 0) ? bus.p0 : bus.p1;
                m_hold[k] = 1'b0;
            end else if (!m_hold[k]) begin
                m_hold[k] = 1'b1;
                m_hv[k] = rfv[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall_ID_EX = 0; bus.stall_EX_DM = 0; bus.flush_ID_EX = 0;
        bus.p0 = 0; bus.p1 = 0; bus.byp0_sel = 0; bus.byp1_sel = 0; bus.byp_data = 0;
        bus.imm_ID_EX = 0; bus.pc_ID_EX = 0; bus.src0sel_ID_EX = 0; bus.src1sel_ID_EX = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.stall_EX_DM = 1'b1;
        look();
        check_eq("rst_src0", 32'(bus.src0), 32'h0);
        check_eq("rst_p0_EX_DM", 32'(bus.p0_EX_DM), 32'h0);

        // RF path
        bus.p0 = 16'h1234; bus.p1 = 16'hABCD;
        tick(); look();
        check_eq("rf_src0", 32'(bus.src0), 32'h1234);
        check_eq("rf_src1", 32'(bus.src1), 32'hABCD);

        // priority bypass
        bus.byp_data = {16'h0002, 16'h0001};
        bus.byp0_sel = 2'b11;
        tick(); look();
        check_eq("byp_prio", 32'(bus.src0), 32'h0001);
        bus.byp0_sel = 2'b10;
        tick(); look();
        check_eq("byp_old", 32'(bus.src0), 32'h0002);

        // stall hold across bypass data change
        bus.byp0_sel = 2'b01; bus.byp_data = {16'h0002, 16'h5555};
        bus.stall_ID_EX = 1'b1;
        look();
        check_eq("hold_c1_src0", 32'(bus.src0), 32'h5555);
        tick();
        bus.byp_data = {16'h0002, 16'h7777};
        look();
        check_eq("hold_c2_src0", 32'(bus.src0), 32'h5555);
        check_eq("hold_c2_flag", 32'(bus.hold0), 32'h1);
        tick(); look();
        check_eq("hold_c3_src0", 32'(bus.src0), 32'h5555);
        tick();
        bus.stall_ID_EX = 1'b0;
        look();
        tick(); look();
        check_eq("release_hold0", 32'(bus.hold0), 32'h0);

        // immediate extension
        bus.imm_ID_EX = 12'h800;
        bus.src0sel_ID_EX = 2'd2; look();
        check_eq("imm_jmp", 32'(bus.src0), 32'hF800);
        tick();
        bus.src0sel_ID_EX = 2'd1; look();
        check_eq("imm_br", 32'(bus.src0), 32'h0000);
        tick();
        bus.imm_ID_EX = 12'h0F8;
        bus.src1sel_ID_EX = 2'd3; look();
        check_eq("imm8", 32'(bus.src1), 32'hFFF8);
        tick();
        bus.src1sel_ID_EX = 2'd2; look();
        check_eq("imm4", 32'(bus.src1), 32'hFFF8);
        tick();
        bus.src0sel_ID_EX = 2'd0; bus.src1sel_ID_EX = 2'd0;

        // flush beats stall
        bus.byp0_sel = 2'b00;
        bus.stall_ID_EX = 1'b1; bus.flush_ID_EX = 1'b1;
        look(); tick();
        bus.flush_ID_EX = 1'b0; bus.stall_ID_EX = 1'b0;
        look();
        check_eq("flush_p0", 32'(bus.src0), 32'h0);
        check_eq("flush_hold0", 32'(bus.hold0), 32'h0);

        // asynchronous reset during a stall
        bus.byp0_sel = 2'b01; bus.stall_ID_EX = 1'b1;
        tick(); look();
        check_eq("pre_rst_hold0", 32'(bus.hold0), 32'h1);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_eq("async_rst_hold0", 32'(bus.hold0), 32'h0);
        check_eq("async_rst_src0", 32'(bus.src0), 32'(m_src0()));
        #1;
        rst_n = 1'b1;
        bus.stall_ID_EX = 1'b0;
        tick();

        // store stall
        bus.stall_EX_DM = 1'b1;
        bus.byp_data = {16'h0002, 16'h00AA};
        look();
        prev_store = m_store;
        tick(); look();
        check_eq("st_stall", 32'(bus.p0_EX_DM), 32'(prev_store));
        bus.stall_EX_DM = 1'b0;
        tick(); look();
        check_eq("st_release", 32'(bus.p0_EX_DM), 32'h00AA);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.p0 = 16'($urandom); bus.p1 = 16'($urandom);
            bus.byp_data = 32'($urandom);
            bus.byp0_sel = 2'($urandom); bus.byp1_sel = 2'($urandom);
            bus.imm_ID_EX = 12'($urandom); bus.pc_ID_EX = 16'($urandom);
            bus.src0sel_ID_EX = 2'($urandom); bus.src1sel_ID_EX = 2'($urandom);
            bus.stall_ID_EX = ($urandom_range(0, 9) < 4);
            bus.flush_ID_EX = ($urandom_range(0, 9) == 0);
            bus.stall_EX_DM = ($urandom_range(0, 9) < 3);
            look();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
